// File: rtl/mvm_feeder_if.sv
// Stream-in and multiplier-side signals of the matrix-vector feeder.
// The slave modport is the feeder's view; the master modport is the environment's view.
interface mvm_feeder_if #(
    parameter int B = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [B-1:0] in_data;
    logic         startMatrix;
    logic         startVector;
    logic         start;
    logic [B-1:0] data_in;
    logic         done;

    modport master (
        output in_valid, in_data, done,
        input  in_ready, startMatrix, startVector, start, data_in
    );

    modport slave (
        input  in_valid, in_data, done,
        output in_ready, startMatrix, startVector, start, data_in
    );
endinterface

// File: rtl/mvm_feeder.sv
// Buffers a K x K matrix and K-vector from a valid/ready stream, then replays them
// to the multiplier as one gap-free startMatrix/startVector/start burst per job.
module mvm_feeder #(
    parameter int K = 3,
    parameter int B = 8
) (
    input  logic        clk,
    input  logic        reset,
    mvm_feeder_if.slave bus,
    output logic        busy
);
    localparam int KK = K * K;
    localparam int N  = KK + K;
    localparam int CW = $clog2(N + 1);
    localparam int DW = $clog2(K + 1);

    typedef enum logic [2:0] {IDLE, MATH, MAT, VECH, VEC, GO, WAIT, DRAIN} state_t;

    state_t        state;
    logic [B-1:0]  mem [N];
    logic [CW-1:0] wcnt;
    logic [CW-1:0] wcnt_next;
    logic [CW-1:0] rcnt;
    logic [CW-1:0] rnext;
    logic [DW-1:0] dcnt;
    logic          accept;
    logic          buf_release;

    // The buffer is handed back to upstream as soon as the last vector word is on data_in.
    always_comb begin
        accept      = bus.in_valid && bus.in_ready;
        buf_release = (state == VEC) && (rcnt == CW'(N - 1));
        rnext       = rcnt + CW'(1);
        wcnt_next   = wcnt;
        if (buf_release) begin
            wcnt_next = '0;
        end else if (accept) begin
            wcnt_next = wcnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wcnt         <= '0;
            bus.in_ready <= 1'b0;
        end else begin
            wcnt         <= wcnt_next;
            bus.in_ready <= (wcnt_next < CW'(N));
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wcnt] <= bus.in_data;
        end
    end

    // Outputs are set on the edge that enters the state they belong to, so every pulse is registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            rcnt            <= '0;
            dcnt            <= '0;
            bus.startMatrix <= 1'b0;
            bus.startVector <= 1'b0;
            bus.start       <= 1'b0;
            bus.data_in     <= '0;
            busy            <= 1'b0;
        end else begin
            bus.startMatrix <= 1'b0;
            bus.startVector <= 1'b0;
            bus.start       <= 1'b0;
            bus.data_in     <= '0;
            case (state)
                IDLE: begin
                    if (wcnt == CW'(N)) begin
                        state           <= MATH;
                        bus.startMatrix <= 1'b1;
                        busy            <= 1'b1;
                    end
                end
                MATH: begin
                    state       <= MAT;
                    rcnt        <= '0;
                    bus.data_in <= mem[0];
                end
                MAT: begin
                    if (rcnt == CW'(KK - 1)) begin
                        state           <= VECH;
                        rcnt            <= CW'(KK);
                        bus.startVector <= 1'b1;
                    end else begin
                        rcnt        <= rnext;
                        bus.data_in <= mem[rnext];
                    end
                end
                VECH: begin
                    state       <= VEC;
                    bus.data_in <= mem[rcnt];
                end
                VEC: begin
                    if (buf_release) begin
                        state     <= GO;
                        rcnt      <= '0;
                        bus.start <= 1'b1;
                    end else begin
                        rcnt        <= rnext;
                        bus.data_in <= mem[rnext];
                    end
                end
                GO: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (bus.done) begin
                        state <= DRAIN;
                        dcnt  <= '0;
                    end
                end
                DRAIN: begin
                    if (dcnt == DW'(K - 1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        dcnt <= dcnt + DW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mvm_feeder.sv
// Self-checking bench for mvm_feeder: directed job table, hand-written corner sequences and
// random jobs, compared cycle by cycle against a schedule-based reference of the feeder.
module tb_mvm_feeder;
    localparam int K  = 3;
    localparam int B  = 8;
    localparam int KK = K * K;
    localparam int N  = KK + K;
    localparam int LIMIT = 3000;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic busy;

    mvm_feeder_if #(.B(B)) bus();

    mvm_feeder #(.K(K), .B(B)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

    typedef struct { int lat; bit spur; } cfg_t;
    typedef struct { int y[K]; } yexp_t;
    typedef struct { int pattern; int stallMode; int lat; bit spur; int y[K]; } vec_t;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    bit           doneSched [int];
    cfg_t         cfgQ [$];
    yexp_t        yQ [$];
    logic [B-1:0] job [N];
    vec_t         vecs [4];

    // Reference state: words held by the feeder, the burst being replayed and its schedule.
    logic [B-1:0] held [$];
    logic [B-1:0] burst [$];
    logic [B-1:0] cap [$];
    int           fullCyc = -1;
    int           launch = -1;
    int           drainEnd = -1;
    int           earliest = 0;
    bit           expReady = 1'b0;
    bit           capturing = 1'b0;
    cfg_t         cur;
    int           o;
    bit           eSm, eSv, eSt, eBusy;
    logic [B-1:0] eData;
    int           acc;
    yexp_t        yGot;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s cycle=%0d actual=%0d expected=%0d", name, cyc, $signed(act), $signed(exp));
        end
    endtask

    initial begin
        bus.done = 1'b0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            bus.done = doneSched.exists(cyc) ? 1'b1 : 1'b0;
        end
    end

    initial forever begin
        @(negedge clk);
        if (!reset) begin
            checkOutput("rst_in_ready", 64'(bus.in_ready), 64'(0));
            checkOutput("rst_startMatrix", 64'(bus.startMatrix), 64'(0));
            checkOutput("rst_startVector", 64'(bus.startVector), 64'(0));
            checkOutput("rst_start", 64'(bus.start), 64'(0));
            checkOutput("rst_data_in", 64'(bus.data_in), 64'(0));
            checkOutput("rst_busy", 64'(busy), 64'(0));
            held.delete(); burst.delete(); cap.delete();
            cfgQ.delete(); yQ.delete(); doneSched.delete();
            fullCyc = -1; launch = -1; drainEnd = -1; earliest = 0;
            expReady = 1'b1; capturing = 1'b0;
        end else begin
            eSm = 0; eSv = 0; eSt = 0; eData = '0;
            o = (launch >= 0) ? cyc - launch : -1;
            if (o == 0) eSm = 1;
            else if (o >= 1 && o <= KK) eData = burst[o - 1];
            else if (o == KK + 1) eSv = 1;
            else if (o >= KK + 2 && o <= N + 1) eData = burst[o - 2];
            else if (o == N + 2) eSt = 1;
            eBusy = (launch >= 0) || (cyc <= drainEnd);
            checkOutput("in_ready", 64'(bus.in_ready), 64'(expReady));
            checkOutput("startMatrix", 64'(bus.startMatrix), 64'(eSm));
            checkOutput("startVector", 64'(bus.startVector), 64'(eSv));
            checkOutput("start", 64'(bus.start), 64'(eSt));
            checkOutput("data_in", 64'(bus.data_in), 64'(eData));
            checkOutput("busy", 64'(busy), 64'(eBusy));

            // Multiplier model: collect the burst, compute y, answer with done.
            if (bus.start === 1'b1) begin
                capturing = 1'b0;
                checkOutput("burst_len", 64'(cap.size()), 64'(N));
                if (cap.size() == N) begin
                    for (int i = 0; i < K; i++) begin
                        acc = 0;
                        for (int j = 0; j < K; j++)
                            acc += int'($signed(cap[i * K + j])) * int'($signed(cap[KK + j]));
                        yGot.y[i] = acc;
                    end
                    checkOutput("y_pending", 64'(yQ.size() > 0), 64'(1));
                    if (yQ.size() > 0) begin
                        yexp_t ye;
                        ye = yQ.pop_front();
                        for (int i = 0; i < K; i++) checkOutput("mult_y", 64'(yGot.y[i]), 64'(ye.y[i]));
                    end
                end
                doneSched[cyc + cur.lat] = 1'b1;
            end else if (capturing && bus.startVector !== 1'b1) begin
                cap.push_back(bus.data_in);
            end
            if (bus.startMatrix === 1'b1) begin
                capturing = 1'b1;
                cap.delete();
                cur.lat = 2; cur.spur = 1'b0;
                if (cfgQ.size() > 0) cur = cfgQ.pop_front();
                if (cur.spur) begin
                    doneSched[cyc + 3] = 1'b1;
                    doneSched[cyc + KK + 1] = 1'b1;
                end
            end

            if (launch >= 0 && o >= N + 3 && bus.done === 1'b1) begin
                drainEnd = cyc + K;
                earliest = cyc + K + 2;
                launch = -1;
            end
            if (bus.in_valid === 1'b1 && expReady) begin
                held.push_back(bus.in_data);
                if (held.size() == N) fullCyc = cyc;
            end
            if (launch >= 0 && o == N + 1) begin
                held.delete();
                fullCyc = -1;
            end
            if (launch < 0 && fullCyc >= 0 && cyc + 1 >= fullCyc + 2 && cyc + 1 >= earliest) begin
                launch = cyc + 1;
                burst = held;
            end
            expReady = (held.size() < N);
        end
    end

    task automatic fillPattern(input int p);
        for (int i = 0; i < N; i++) begin
            case (p)
                0: job[i] = (i < KK) ? B'(i + 1) : B'((i - KK + 1) * (((i - KK) % 2 == 0) ? -1 : 1));
                1: job[i] = (i < KK) ? 8'h80 : 8'h7F;
                default: job[i] = B'($urandom);
            endcase
        end
    endtask

    function automatic yexp_t refY();
        yexp_t r;
        for (int i = 0; i < K; i++) begin
            r.y[i] = 0;
            for (int j = 0; j < K; j++)
                r.y[i] += int'($signed(job[i * K + j])) * int'($signed(job[KK + j]));
        end
        return r;
    endfunction

    task automatic applyStimulus(input int stallMode, input int lat, input bit spur, input yexp_t ye);
        cfg_t c;
        bit   ok;
        int   guard;
        c.lat = lat; c.spur = spur;
        cfgQ.push_back(c);
        yQ.push_back(ye);
        for (int i = 0; i < N; i++) begin
            if (stallMode == 1 || (stallMode == 2 && $urandom_range(0, 2) == 0)) begin
                bus.in_valid = 1'b0;
                @(posedge clk); #1;
            end
            bus.in_valid = 1'b1;
            bus.in_data = job[i];
            guard = 0;
            do begin
                @(negedge clk);
                ok = bus.in_ready;
                @(posedge clk); #1;
                guard++;
            end while (!ok && guard < LIMIT);
            if (!ok) begin
                checks++; errors++;
                $display("[TB] FAIL accept_timeout word=%0d actual=no_accept expected=accept", i);
                bus.in_valid = 1'b0;
                return;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic waitIdle();
        int g;
        g = 0;
        while ((yQ.size() != 0 || busy !== 1'b0) && g < LIMIT) begin
            @(posedge clk); #1;
            g++;
        end
        checkOutput("idle_reached", 64'(g < LIMIT), 64'(1));
    endtask

    initial begin
        yexp_t ye;
        int    g;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        vecs[0] = '{pattern: 0, stallMode: 0, lat: 2, spur: 1'b0, y: '{-6, -12, -18}};
        vecs[1] = '{pattern: 0, stallMode: 1, lat: 3, spur: 1'b0, y: '{-6, -12, -18}};
        vecs[2] = '{pattern: 0, stallMode: 0, lat: 1, spur: 1'b0, y: '{-6, -12, -18}};
        vecs[3] = '{pattern: 1, stallMode: 0, lat: 4, spur: 1'b1, y: '{-48768, -48768, -48768}};

        repeat (2) @(negedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < 4; v++) begin
            fillPattern(vecs[v].pattern);
            ye.y = vecs[v].y;
            applyStimulus(vecs[v].stallMode, vecs[v].lat, vecs[v].spur, ye);
        end
        waitIdle();

        // 0x55 waits at the input while the first job is full and becomes a[0][0] of the second.
        fillPattern(0);
        ye.y = '{-6, -12, -18};
        applyStimulus(0, 6, 1'b0, ye);
        fillPattern(2);
        job[0] = 8'h55;
        applyStimulus(0, 2, 1'b0, refY());
        waitIdle();

        // Reset while the fifth matrix word is on data_in, then a fresh job.
        fillPattern(0);
        ye.y = '{-6, -12, -18};
        applyStimulus(0, 2, 1'b0, ye);
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (bus.startMatrix !== 1'b1 && g < LIMIT);
        checkOutput("launch_before_reset", 64'(g < LIMIT), 64'(1));
        repeat (5) @(negedge clk);
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        fillPattern(1);
        ye.y = '{-48768, -48768, -48768};
        applyStimulus(0, 3, 1'b0, ye);
        waitIdle();

        for (int r = 0; r < 8; r++) begin
            fillPattern(2);
            applyStimulus(2, int'($urandom_range(1, 6)), bit'($urandom_range(0, 1)), refY());
        end
        waitIdle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mvm_feeder.md
# mvm_feeder

Upstream loader for the matrix-vector multiplier. Accepts a K×K matrix followed by a K-vector as a valid/ready word stream and stores all K·K+K words in an internal buffer. It then replays them to the multiplier as one gap-free burst using the multiplier's startMatrix / startVector / start protocol. It waits for done and the K result cycles before issuing the next job, and accepts the next job's words while the current job computes.

## Interface

Parameters:
- K, 3, matrix dimension (MAT_SCALE); K ≥ 2
- B, 8, data word width (INPUT_WIDTH)

Ports:
- clk  in  1  single clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream word valid
- in_ready  out  1  feeder can accept a word
- in_data  in  B  signed word; row-major matrix a[0][0]..a[K-1][K-1], then x[0]..x[K-1]
- startMatrix  out  1  one-cycle pulse to multiplier
- startVector  out  1  one-cycle pulse to multiplier
- start  out  1  one-cycle pulse to multiplier
- data_in  out  B  word to multiplier
- done  in  1  multiplier done; results follow on the next K cycles
- busy  out  1  an issue is in progress (state ≠ IDLE)

## Operation

- Buffer: N = K·K+K words, written by write counter wcnt (0..N) and read by read counter rcnt (0..N-1).
- Transfer: a word transfers when in_valid && in_ready. It is written at buf[wcnt], and wcnt then increments.
- in_ready = (wcnt < N). It is a registered flag and is combinationally independent of in_valid.
- Buffer release: wcnt returns to 0 on the cycle the last buffered word (x[K-1]) is driven in VEC. in_ready rises the following cycle, so the next job loads during GO/WAIT/DRAIN.
- Issue FSM states:
  - IDLE: if wcnt == N, go to MATH.
  - MATH: startMatrix=1; rcnt=0; go to MAT.
  - MAT: data_in=buf[rcnt]; rcnt++. After K·K words, go to VECH.
  - VECH: startVector=1; go to VEC.
  - VEC: data_in=buf[rcnt]; rcnt++. After K words, go to GO and release the buffer.
  - GO: start=1; go to WAIT.
  - WAIT: hold until done==1, then go to DRAIN with dcnt=0.
  - DRAIN: dcnt++. After K cycles, go to IDLE.
- done is ignored in every state except WAIT.
- data_in = 0 outside MAT/VEC. All pulses are exactly one cycle.
- No arithmetic on data; words pass through bit-exact.
- Counters are sized to hold N and K·K; no counter wraps.

## Timing

- Reset values (asserted asynchronously): state=IDLE; wcnt=rcnt=dcnt=0; in_ready=1 after first clock edge with reset released (0 during reset); startMatrix=startVector=start=0; data_in=0; busy=0.
- All outputs are registered.
- Load: one word per cycle at full rate. The N-th accept makes wcnt == N and drops in_ready the next cycle.
- Launch: in_ready drops at edge t. At edge t+1 the FSM enters MATH and startMatrix is high during cycle t+1.
- Burst timing, relative to startMatrix in cycle s:
  - matrix words occupy s+1..s+K·K;
  - startVector at s+K·K+1;
  - vector words s+K·K+2..s+K·K+K+1;
  - start at s+K·K+K+2.
- The burst has no gaps regardless of upstream stalls.
- done seen high in WAIT at cycle d: DRAIN occupies d+1..d+K, and IDLE is reached at d+K+1. If the buffer is full then, startMatrix is high at d+K+2.
- Reset mid-operation: the FSM aborts immediately. Buffer contents are discarded (wcnt=0) and all pulses are deasserted.
- Upstream hold: in_valid held while in_ready=0 is legal. The word is not consumed, and in_data must be held stable by upstream.

## Test plan

K=3, B=8 (N=12) throughout.

- Basic job:
  - Stimulus: stream a = 1..9, x = -1,2,-3 with continuous in_valid.
  - Required: startMatrix is 1 cycle after in_ready falls. data_in shows 1..9, then startVector, then -1,2,-3, then start. The multiplier model returns y = -6,-12,-18. busy falls 4 cycles after done.
- Upstream stalls:
  - Stimulus: same data with in_valid low on every other cycle.
  - Required: the burst to the multiplier is identical and gap-free (startMatrix to start spans exactly 15 cycles).
- Overlap:
  - Stimulus: present job 2 (a = -128 ×9, x = 127 ×3) immediately after job 1.
  - Required: in_ready rises the cycle after job 1's x[2] is driven. Job 2's startMatrix is not asserted until job 1's DRAIN ends. Job 2 words are unchanged, including the extremes -128/127.
- Spurious done:
  - Stimulus: pulse done during MAT and during VECH.
  - Required: no state change. The burst completes normally and WAIT still waits for a real done.
- Mid-operation reset:
  - Stimulus: assert reset low during MAT word 5, release, then send a fresh job.
  - Required: all outputs are 0 during reset, in_ready returns, and the fresh job issues correctly with no residue of the old words.
- Backpressure at full:
  - Stimulus: hold in_valid=1 with word 0x55 while the buffer is full through WAIT.
  - Required: in_ready=0, the word is not written, and it is accepted as a[0][0] of the next job after release.
